// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer around one shared combinational full adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (a, b, cin)
//   out_valid/out_ready   result handshake (sum, cout[, ovf])
//   fa_a/fa_b/fa_cin      operand bits to the external FA
//   fa_s/fa_cout          same-cycle FA results
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry_q;
            if (cnt == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sum bits enter at the MSB so that after WIDTH shifts the
   // LSB-first results line up in natural order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_q <= cin;
                  cnt     <= '0;
               end
            end
            RUN: begin
               sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry_q <= fa_cout;
               cnt     <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_sh;
   assign cout = carry_q;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // On the MSB step carry_q still holds the carry into the MSB
   // and fa_cout is the final carry-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && cnt == LAST) begin
         ovf_q <= carry_q ^ fa_cout;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
